// File: rtl/disp_reg_pkg.sv
// Register map, bit positions and helpers shared by the display register file.
package disp_reg_pkg;

  typedef logic [31:0] word_t;

  localparam logic [15:0] ADDR_DISPADDR   = 16'h0000;
  localparam logic [15:0] ADDR_DISPCTRL   = 16'h0004;
  localparam logic [15:0] ADDR_DISPINT    = 16'h0008;
  localparam logic [15:0] ADDR_DISPFIFO   = 16'h000C;
  localparam logic [15:0] ADDR_DISPLAYER  = 16'h0010;
  localparam logic [15:0] ADDR_DISPFRAME  = 16'h0014;
  localparam logic [15:0] ADDR_LAYER_BASE = 16'h0020;
  localparam logic [15:0] LAYER_STRIDE    = 16'h0004;

  localparam int unsigned CTRL_DISPON_BIT = 0;
  localparam int unsigned CTRL_VBLANK_BIT = 1;
  localparam int unsigned INT_ENBL_BIT    = 0;
  localparam int unsigned INT_CLR_BIT     = 1;
  localparam int unsigned INT_STAT_BIT    = 2;
  localparam int unsigned FIFO_OVER_BIT   = 0;
  localparam int unsigned FIFO_UNDER_BIT  = 1;

  function automatic logic [15:0] layer_offset(input int unsigned idx);
    return ADDR_LAYER_BASE + LAYER_STRIDE * 16'(idx);
  endfunction

  function automatic word_t byte_merge(input word_t old_val, input word_t wdata,
                                       input logic [3:0] be);
    word_t res;
    res = old_val;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) res[8*k +: 8] = wdata[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/disp_regfile_ml_if.sv
// Register write/read bus of the display register file.
interface disp_regfile_ml_if;
  // No backpressure: WREN and RDEN are qualifiers accepted on every ACLK edge;
  // read data appears on RDATA two cycles after the RDEN cycle and then holds.
  logic [15:0] WRADDR;
  logic [3:0]  BYTEEN;
  logic        WREN;
  logic [31:0] WDATA;
  logic [15:0] RDADDR;
  logic        RDEN;
  logic [31:0] RDATA;

  modport master (output WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, input RDATA);
  modport slave  (input WRADDR, BYTEEN, WREN, WDATA, RDADDR, RDEN, output RDATA);
endinterface

// File: rtl/disp_w1c_flag.sv
// Sticky status flag: set by an event pulse, cleared by a write-1, set wins on collision.
module disp_w1c_flag (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic flag_o
);

  logic flag_q, flag_d;

  always_comb begin
    flag_d = flag_q;
    if (clr_i) flag_d = 1'b0;
    if (set_i) flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) flag_q <= 1'b0;
    else     flag_q <= flag_d;
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/disp_regfile_ml.sv
// Display controller register file with two-stage read pipeline.
// Optional DISP_SHADOW_EN: layer addresses commit from pending copies on VBLANK_PULSE.
module disp_regfile_ml
  import disp_reg_pkg::*;
#(
  parameter int NUM_LAYERS  = 2,
  parameter int FRAME_CNT_W = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  disp_regfile_ml_if.slave        bus,
  input  logic                    VBLANK_PULSE,
  input  logic                    FIFO_OVER,
  input  logic                    FIFO_UNDER,
  output logic                    DISPON,
  output logic [NUM_LAYERS-1:0]   LAYER_EN,
  output logic [32*NUM_LAYERS-1:0] LAYER_ADDR,
  output logic                    DSP_IRQ
);

  localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = {{(FRAME_CNT_W-1){1'b0}}, 1'b1};

  logic                   dispon_q, dispon_d;
  logic                   intenbl_q, intenbl_d;
  logic [NUM_LAYERS-1:0]  layer_en_q, layer_en_d;
  logic [FRAME_CNT_W-1:0] frame_q, frame_d;
  word_t                  layer_pend_q [NUM_LAYERS];
  word_t                  layer_pend_d [NUM_LAYERS];
  logic                   irq_q, irq_d;
  logic                   rd_vld_q, rd_vld_d;
  word_t                  rd_stage_q, rd_stage_d;
  word_t                  rdata_q, rdata_d;
  word_t                  rd_mux;

  logic wr_ctrl, wr_int, wr_fifo, wr_layer;
  logic vblank_clr, irq_clr, over_clr, under_clr;
  logic vblank_flag, irq_stat, over_flag, under_flag;

  assign wr_ctrl  = bus.WREN && (bus.WRADDR == ADDR_DISPCTRL);
  assign wr_int   = bus.WREN && (bus.WRADDR == ADDR_DISPINT);
  assign wr_fifo  = bus.WREN && (bus.WRADDR == ADDR_DISPFIFO);
  assign wr_layer = bus.WREN && (bus.WRADDR == ADDR_DISPLAYER);

  // All single-bit control and clear fields live in byte 0.
  assign vblank_clr = wr_ctrl && bus.BYTEEN[0] && bus.WDATA[CTRL_VBLANK_BIT];
  assign irq_clr    = wr_int  && bus.BYTEEN[0] && bus.WDATA[INT_CLR_BIT];
  assign over_clr   = wr_fifo && bus.BYTEEN[0] && bus.WDATA[FIFO_OVER_BIT];
  assign under_clr  = wr_fifo && bus.BYTEEN[0] && bus.WDATA[FIFO_UNDER_BIT];

  disp_w1c_flag u_vblank (.clk(ACLK), .rst(ARESET), .set_i(VBLANK_PULSE),
                          .clr_i(vblank_clr), .flag_o(vblank_flag));
  disp_w1c_flag u_irq    (.clk(ACLK), .rst(ARESET), .set_i(VBLANK_PULSE && dispon_q),
                          .clr_i(irq_clr), .flag_o(irq_stat));
  disp_w1c_flag u_over   (.clk(ACLK), .rst(ARESET), .set_i(FIFO_OVER),
                          .clr_i(over_clr), .flag_o(over_flag));
  disp_w1c_flag u_under  (.clk(ACLK), .rst(ARESET), .set_i(FIFO_UNDER),
                          .clr_i(under_clr), .flag_o(under_flag));

  always_comb begin
    dispon_d   = dispon_q;
    intenbl_d  = intenbl_q;
    layer_en_d = layer_en_q;
    if (wr_ctrl && bus.BYTEEN[0])  dispon_d   = bus.WDATA[CTRL_DISPON_BIT];
    if (wr_int && bus.BYTEEN[0])   intenbl_d  = bus.WDATA[INT_ENBL_BIT];
    if (wr_layer && bus.BYTEEN[0]) layer_en_d = bus.WDATA[NUM_LAYERS-1:0];
    frame_d = frame_q;
    if (VBLANK_PULSE && dispon_q) frame_d = frame_q + FRAME_ONE;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      layer_pend_d[i] = layer_pend_q[i];
      if (bus.WREN && ((bus.WRADDR == layer_offset(i)) ||
                       (i == 0 && bus.WRADDR == ADDR_DISPADDR)))
        layer_pend_d[i] = byte_merge(layer_pend_q[i], bus.WDATA, bus.BYTEEN);
    end
    irq_d      = intenbl_q && irq_stat;
    rd_vld_d   = bus.RDEN;
    rd_stage_d = rd_mux;
    rdata_d    = rd_vld_q ? rd_stage_q : rdata_q;
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
  always_comb begin
    rd_mux = '0;
    case (bus.RDADDR)
      ADDR_DISPADDR: rd_mux = layer_pend_q[0];
      ADDR_DISPCTRL: begin
        rd_mux[CTRL_DISPON_BIT] = dispon_q;
        rd_mux[CTRL_VBLANK_BIT] = vblank_flag;
      end
      ADDR_DISPINT: begin
        rd_mux[INT_ENBL_BIT] = intenbl_q;
        rd_mux[INT_STAT_BIT] = irq_stat;
      end
      ADDR_DISPFIFO: begin
        rd_mux[FIFO_OVER_BIT]  = over_flag;
        rd_mux[FIFO_UNDER_BIT] = under_flag;
      end
      ADDR_DISPLAYER: rd_mux[NUM_LAYERS-1:0]  = layer_en_q;
      ADDR_DISPFRAME: rd_mux[FRAME_CNT_W-1:0] = frame_q;
      default: begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
          if (bus.RDADDR == layer_offset(i)) rd_mux = layer_pend_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      dispon_q   <= 1'b0;
      intenbl_q  <= 1'b0;
      layer_en_q <= '0;
      frame_q    <= '0;
      irq_q      <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_stage_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) layer_pend_q[i] <= '0;
    end else begin
      dispon_q   <= dispon_d;
      intenbl_q  <= intenbl_d;
      layer_en_q <= layer_en_d;
      frame_q    <= frame_d;
      irq_q      <= irq_d;
      rd_vld_q   <= rd_vld_d;
      rd_stage_q <= rd_stage_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NUM_LAYERS; i++) layer_pend_q[i] <= layer_pend_d[i];
    end
  end

`ifdef DISP_SHADOW_EN
  word_t layer_cmt_q [NUM_LAYERS];
  word_t layer_cmt_d [NUM_LAYERS];

  // Commit takes the next-pending value so a write coinciding with vblank lands.
  always_comb begin
    for (int i = 0; i < NUM_LAYERS; i++)
      layer_cmt_d[i] = VBLANK_PULSE ? layer_pend_d[i] : layer_cmt_q[i];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_LAYERS; i++) layer_cmt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) layer_cmt_q[i] <= layer_cmt_d[i];
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer_out
    assign LAYER_ADDR[32*g +: 32] = layer_cmt_q[g];
  end
`else
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer_out
    assign LAYER_ADDR[32*g +: 32] = layer_pend_q[g];
  end
`endif

  assign DISPON    = dispon_q;
  assign LAYER_EN  = layer_en_q;
  assign DSP_IRQ   = irq_q;
  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_disp_regfile_ml.sv
// Directed self-checking bench for disp_regfile_ml (NUM_LAYERS=2, FRAME_CNT_W=8).
module tb_disp_regfile_ml;
  import disp_reg_pkg::*;

  logic        aclk;
  logic        areset;
  logic        vblank_pulse, fifo_over, fifo_under;
  logic        dispon, dsp_irq;
  logic [1:0]  layer_en;
  logic [63:0] layer_addr;
  logic [31:0] exp_q[$];
  int          n_tests;
  int          n_fail;

  disp_regfile_ml_if bus ();

  disp_regfile_ml #(.NUM_LAYERS(2), .FRAME_CNT_W(8)) dut (
    .ACLK(aclk), .ARESET(areset), .bus(bus),
    .VBLANK_PULSE(vblank_pulse), .FIFO_OVER(fifo_over), .FIFO_UNDER(fifo_under),
    .DISPON(dispon), .LAYER_EN(layer_en), .LAYER_ADDR(layer_addr), .DSP_IRQ(dsp_irq)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wr(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus.WRADDR = addr;
    bus.BYTEEN = be;
    bus.WDATA  = data;
    bus.WREN   = 1'b1;
    tick();
    bus.WREN   = 1'b0;
  endtask

  task automatic pulse(input logic vb, input logic ov, input logic un);
    vblank_pulse = vb;
    fifo_over    = ov;
    fifo_under   = un;
    tick();
    vblank_pulse = 1'b0;
    fifo_over    = 1'b0;
    fifo_under   = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    bus.RDADDR = addr;
    bus.RDEN   = 1'b1;
    tick();
    bus.RDEN   = 1'b0;
    tick();
    check(tag, {32'h0, bus.RDATA}, {32'h0, exp_q.pop_front()});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    areset = 1'b1;
    vblank_pulse = 1'b0; fifo_over = 1'b0; fifo_under = 1'b0;
    bus.WRADDR = '0; bus.BYTEEN = '0; bus.WREN = 1'b0; bus.WDATA = '0;
    bus.RDADDR = '0; bus.RDEN = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    tick();

    check("rst_dispon", {63'h0, dispon}, 64'h0);
    check("rst_layer_en", {62'h0, layer_en}, 64'h0);
    check("rst_layer_addr", layer_addr, 64'h0);
    check("rst_irq", {63'h0, dsp_irq}, 64'h0);
    check("rst_rdata", {32'h0, bus.RDATA}, 64'h0);

    // byte-lane writes assemble DISPADDR; read latency is two cycles
    wr(ADDR_DISPADDR, 4'b0001, 32'h0000_0078);
    wr(ADDR_DISPADDR, 4'b0010, 32'h0000_5600);
    wr(ADDR_DISPADDR, 4'b0100, 32'h0034_0000);
    wr(ADDR_DISPADDR, 4'b1000, 32'h1200_0000);
    bus.RDADDR = ADDR_DISPADDR;
    bus.RDEN   = 1'b1;
    tick();
    bus.RDEN   = 1'b0;
    check("rd_lat_first_edge", {32'h0, bus.RDATA}, 64'h0);
    tick();
    check("rd_dispaddr_bytes", {32'h0, bus.RDATA}, 64'h1234_5678);
    rd_check("rd_layer0_alias", 16'h0020, 32'h1234_5678);
`ifdef DISP_SHADOW_EN
    check("layer0_not_committed", layer_addr, 64'h0);
`else
    check("layer0_direct", layer_addr, 64'h0000_0000_1234_5678);
`endif

    // layer 1 write, readback of pending value, commit on vblank
    wr(16'h0024, 4'b1111, 32'h2012_C000);
`ifdef DISP_SHADOW_EN
    check("layer1_before_vblank", {32'h0, layer_addr[63:32]}, 64'h0);
`else
    check("layer1_direct", {32'h0, layer_addr[63:32]}, 64'h2012_C000);
`endif
    rd_check("rd_layer1_pending", 16'h0024, 32'h2012_C000);
    pulse(1'b1, 1'b0, 1'b0);
    check("layer_after_vblank", layer_addr, 64'h2012_C000_1234_5678);
    rd_check("rd_ctrl_vblank", ADDR_DISPCTRL, 32'h2);
    wr(ADDR_DISPCTRL, 4'b0001, 32'h2);
    rd_check("rd_ctrl_w1c", ADDR_DISPCTRL, 32'h0);

    // interrupt path
    wr(ADDR_DISPCTRL, 4'b0001, 32'h1);
    wr(ADDR_DISPINT, 4'b0001, 32'h1);
    pulse(1'b1, 1'b0, 1'b0);
    check("irq_lag", {63'h0, dsp_irq}, 64'h0);
    tick();
    check("irq_set", {63'h0, dsp_irq}, 64'h1);
    rd_check("rd_int_status", ADDR_DISPINT, 32'h5);
    wr(ADDR_DISPINT, 4'b0001, 32'h3);
    tick();
    check("irq_cleared", {63'h0, dsp_irq}, 64'h0);
    vblank_pulse = 1'b1;
    wr(ADDR_DISPINT, 4'b0001, 32'h3);
    vblank_pulse = 1'b0;
    tick();
    check("irq_set_wins", {63'h0, dsp_irq}, 64'h1);
    rd_check("rd_int_set_wins", ADDR_DISPINT, 32'h5);
    rd_check("rd_frame_2", ADDR_DISPFRAME, 32'h2);
    rd_check("rd_ctrl_on_vb", ADDR_DISPCTRL, 32'h3);

    // FIFO sticky flags
    pulse(1'b0, 1'b1, 1'b0);
    rd_check("rd_fifo_over", ADDR_DISPFIFO, 32'h1);
    wr(ADDR_DISPFIFO, 4'b0001, 32'h3);
    rd_check("rd_fifo_clr", ADDR_DISPFIFO, 32'h0);
    pulse(1'b0, 1'b0, 1'b1);
    rd_check("rd_fifo_under", ADDR_DISPFIFO, 32'h2);

    // layer enables, read-only frame counter, unmapped space
    wr(ADDR_DISPLAYER, 4'b1111, 32'hFFFF_FFFF);
    check("layer_en_out", {62'h0, layer_en}, 64'h3);
    rd_check("rd_displayer", ADDR_DISPLAYER, 32'h3);
    wr(ADDR_DISPFRAME, 4'b1111, 32'h0000_00FF);
    rd_check("rd_frame_ro", ADDR_DISPFRAME, 32'h2);
    wr(16'h0018, 4'b1111, 32'hDEAD_BEEF);
    rd_check("rd_unmapped", 16'h0018, 32'h0);

    // same-cycle write and read return the old value
    exp_q.push_back(32'h1234_5678);
    bus.WRADDR = ADDR_DISPADDR; bus.BYTEEN = 4'b1111; bus.WDATA = 32'hAABB_CCDD;
    bus.WREN = 1'b1;
    bus.RDADDR = ADDR_DISPADDR; bus.RDEN = 1'b1;
    tick();
    bus.WREN = 1'b0; bus.RDEN = 1'b0;
    tick();
    check("rd_pre_write", {32'h0, bus.RDATA}, {32'h0, exp_q.pop_front()});
    rd_check("rd_post_write", ADDR_DISPADDR, 32'hAABB_CCDD);

    // 8-bit frame counter wraps; frozen while display off
    for (int i = 0; i < 253; i++) pulse(1'b1, 1'b0, 1'b0);
    rd_check("rd_frame_ff", ADDR_DISPFRAME, 32'hFF);
    pulse(1'b1, 1'b0, 1'b0);
    rd_check("rd_frame_wrap", ADDR_DISPFRAME, 32'h0);
    wr(ADDR_DISPCTRL, 4'b0001, 32'h0);
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, 1'b0);
    rd_check("rd_frame_off", ADDR_DISPFRAME, 32'h0);
    check("dispon_off", {63'h0, dispon}, 64'h0);

    // reset with a read in flight, flags set and events/writes during reset
    wr(ADDR_DISPCTRL, 4'b0001, 32'h1);
    pulse(1'b1, 1'b1, 1'b0);
    tick();
    rd_check("rd_before_reset", ADDR_DISPADDR, 32'hAABB_CCDD);
    bus.RDADDR = ADDR_DISPADDR;
    bus.RDEN   = 1'b1;
    tick();
    bus.RDEN   = 1'b0;
    areset = 1'b1;
    vblank_pulse = 1'b1; fifo_under = 1'b1;
    bus.WRADDR = ADDR_DISPCTRL; bus.BYTEEN = 4'b1111; bus.WDATA = 32'h1; bus.WREN = 1'b1;
    tick();
    check("mid_rst_rdata", {32'h0, bus.RDATA}, 64'h0);
    check("mid_rst_dispon", {63'h0, dispon}, 64'h0);
    check("mid_rst_irq", {63'h0, dsp_irq}, 64'h0);
    check("mid_rst_layer_en", {62'h0, layer_en}, 64'h0);
    check("mid_rst_layer_addr", layer_addr, 64'h0);
    areset = 1'b0;
    vblank_pulse = 1'b0; fifo_under = 1'b0; bus.WREN = 1'b0;
    tick();
    check("post_rst_rdata", {32'h0, bus.RDATA}, 64'h0);
    rd_check("rd_ctrl_after_rst", ADDR_DISPCTRL, 32'h0);
    rd_check("rd_fifo_after_rst", ADDR_DISPFIFO, 32'h0);
    rd_check("rd_frame_after_rst", ADDR_DISPFRAME, 32'h0);
    rd_check("rd_addr_after_rst", ADDR_DISPADDR, 32'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_regfile_ml.md
DISP_REGFILE_ML -- requirements
Module: disp_regfile_ml

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 2, number of display layers (legal 1..4).
REQ-002 SHALL have parameter FRAME_CNT_W, default 32, frame counter width (legal 8..32).
REQ-003 SHALL have ports ACLK  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have ports ARESET  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports WRADDR  input  16, BYTEEN  input  4, WREN  input  1, WDATA  input  32  register write bus.
REQ-006 SHALL have ports RDADDR  input  16, RDEN  input  1, RDATA  output  32  register read bus.
REQ-007 SHALL have ports VBLANK_PULSE, FIFO_OVER, FIFO_UNDER  input  1 each  single-cycle ACLK-domain event pulses.
REQ-008 SHALL have ports DISPON  output  1, LAYER_EN  output  NUM_LAYERS, LAYER_ADDR  output  32*NUM_LAYERS, DSP_IRQ  output  1.

Function
REQ-009 Address map: 0x0000 DISPADDR (alias of layer 0), 0x0004 DISPCTRL, 0x0008 DISPINT, 0x000C DISPFIFO, 0x0010 DISPLAYER, 0x0014 DISPFRAME, 0x0020+4*i layer i address; others unmapped.
REQ-010 Writes take effect on the ACLK edge where WREN=1; only bytes with BYTEEN[k]=1 updated; unmapped writes ignored.
REQ-011 DISPCTRL: bit0 DISPON R/W; bit1 VBLANK sticky flag, set by VBLANK_PULSE, write-1-to-clear via byte 0.
REQ-012 DISPINT: bit0 INTENBL R/W; bit1 INTCLR write-only (reads 0); bit2 IRQ status, set by VBLANK_PULSE when DISPON=1, cleared by INTCLR=1.
REQ-013 DSP_IRQ SHALL be registered INTENBL & IRQ status (one cycle after either changes).
REQ-014 DISPFIFO: bit0 OVER, bit1 UNDER sticky flags set by FIFO_OVER/FIFO_UNDER, write-1-to-clear.
REQ-015 Any sticky flag: simultaneous set pulse and clear write -> set wins.
REQ-016 DISPLAYER: bits[NUM_LAYERS-1:0] R/W layer enables driving LAYER_EN; upper bits read 0.
REQ-017 DISPFRAME: read-only count of VBLANK_PULSE events while DISPON=1, wraps to 0 after all-ones; writes ignored; upper bits beyond FRAME_CNT_W read 0.
REQ-018 Read latency: RDATA SHALL reflect register contents addressed by RDADDR two edges after an edge with RDEN=1; RDATA holds last value when no read in flight; unmapped reads return 0.
REQ-019 Layer address reads return the software-written (pending) value, never the committed value.
REQ-020 Write and read to same address in same cycle: read returns pre-write value.

Reset
REQ-021 ARESET=1 at an edge SHALL zero all registers: DISPON=0, LAYER_EN=0, LAYER_ADDR=0, DSP_IRQ=0, RDATA=0, all flags, counter and read pipeline; in-flight reads discarded.
REQ-022 Event pulses and writes during reset SHALL be ignored.

Configuration
REQ-023 Macro DISP_SHADOW_EN defined: layer addresses double-buffered; writes go to pending register; pending copied to LAYER_ADDR on the edge after VBLANK_PULSE; write coinciding with VBLANK_PULSE commits new value.
REQ-024 DISP_SHADOW_EN undefined: LAYER_ADDR updated directly, visible one cycle after write.

Structure
REQ-025 Package disp_reg_pkg SHALL hold register offsets, bit positions and layer address stride.
REQ-026 Sub-module disp_w1c_flag (sticky flag, set-priority, write-1-clear) SHALL be instantiated for VBLANK, IRQ, OVER, UNDER.

Verification
REQ-027 Byte writes 0x78/0x5600/0x340000/0x12000000 to DISPADDR with BYTEEN 0001/0010/0100/1000 -> read returns 0x12345678, RDATA valid 2 cycles after RDEN.
REQ-028 DISP_SHADOW_EN: write layer1 0x2012C000 -> LAYER_ADDR[63:32] unchanged until VBLANK_PULSE, then 0x2012C000 next cycle; readback immediate 0x2012C000.
REQ-029 DISPON=1, INTENBL=1, VBLANK_PULSE -> DSP_IRQ=1 one cycle after status; write DISPINT=0x3 -> DSP_IRQ=0; same-cycle pulse+clear -> stays 1.
REQ-030 FIFO_OVER pulse -> DISPFIFO=0x1; write 0x3 -> 0x0; FIFO_UNDER pulse -> 0x2.
REQ-031 FRAME_CNT_W=8, 256 VBLANK_PULSEs with DISPON=1 -> DISPFRAME=0; with DISPON=0 count unchanged.
REQ-032 ARESET mid-read with DISPON=1, flags set -> all outputs 0 next edge, RDATA=0.
